// File: rtl/ap_adder_sigmoid_random_if.sv
// Bus bundle for ap_adder_sigmoid_random: adder operands/result, sigmoid
// argument/probability, LFSR seed/state and the stochastic sample bit.
interface ap_adder_sigmoid_random_if #(
    parameter int BITLENGTH         = 16,
    parameter int SIGMOID_BITLENGTH = 8
);
    logic [SIGMOID_BITLENGTH-1:0] seed;
    logic [BITLENGTH-1:0]         add_a;
    logic [BITLENGTH-1:0]         add_b;
    logic [BITLENGTH-1:0]         sum;
    logic [BITLENGTH-1:0]         sig_in;
    logic [SIGMOID_BITLENGTH-1:0] prob;
    logic [SIGMOID_BITLENGTH-1:0] rand_data;
    logic                         sample;

    modport master (
        output seed, add_a, add_b, sig_in,
        input  sum, prob, rand_data, sample
    );

    modport slave (
        input  seed, add_a, add_b, sig_in,
        output sum, prob, rand_data, sample
    );
endinterface

// File: rtl/ap_adder_sigmoid_random.sv
// Saturating/wrapping adder, piecewise-linear sigmoid and 8-bit LFSR sampler.
// Build macro AP_ADDER_SAT_EN: defined -> saturating adder, undefined -> wrap-around adder.
module ap_adder_sigmoid_random #(
    parameter int                   BITLENGTH         = 16,
    parameter int                   SIGMOID_BITLENGTH = 8,
    parameter logic [BITLENGTH-1:0] INF               = 16'h7FFF
) (
    input  logic                     clock,
    input  logic                     reset,
    ap_adder_sigmoid_random_if.slave bus
);

    localparam logic [BITLENGTH-1:0] X_MIN = {1'b1, {(BITLENGTH-1){1'b0}}};
    localparam logic [BITLENGTH-1:0] X_MAX = {1'b0, {(BITLENGTH-1){1'b1}}};
    localparam logic [BITLENGTH-1:0] T_SAT = BITLENGTH'(32'd1280);
    localparam logic [BITLENGTH-1:0] T_MID = BITLENGTH'(32'd608);
    localparam logic [BITLENGTH-1:0] T_ONE = BITLENGTH'(32'd256);

    logic [BITLENGTH-1:0]         sum_s;
    logic [BITLENGTH-1:0]         t_s;
    logic [8:0]                   p_s;
    logic [8:0]                   q_s;
    logic [SIGMOID_BITLENGTH-1:0] prob_s;
    logic [SIGMOID_BITLENGTH-1:0] seed_load_s;
    logic [SIGMOID_BITLENGTH-1:0] lfsr_d;
    logic [SIGMOID_BITLENGTH-1:0] lfsr_q;

`ifdef AP_ADDER_SAT_EN
    localparam logic signed [BITLENGTH:0] POS_LIM = $signed({1'b0, INF});
    localparam logic signed [BITLENGTH:0] NEG_LIM = -POS_LIM;

    logic signed [BITLENGTH:0] sum_full_s;

    // Full-precision sum clamped symmetrically to +/-INF.
    always_comb begin
        sum_full_s = $signed({bus.add_a[BITLENGTH-1], bus.add_a})
                   + $signed({bus.add_b[BITLENGTH-1], bus.add_b});
        if (sum_full_s > POS_LIM) begin
            sum_s = POS_LIM[BITLENGTH-1:0];
        end else if (sum_full_s < NEG_LIM) begin
            sum_s = NEG_LIM[BITLENGTH-1:0];
        end else begin
            sum_s = sum_full_s[BITLENGTH-1:0];
        end
    end
`else
    // Plain two's-complement sum, carry out discarded.
    always_comb begin
        sum_s = bus.add_a + bus.add_b;
    end
`endif

    // Sigmoid: fold to |x| (most-negative maps to max positive), evaluate
    // the positive branch, mirror for negative x, clamp to 8 bits.
    always_comb begin
        if (bus.sig_in == X_MIN) begin
            t_s = X_MAX;
        end else if (bus.sig_in[BITLENGTH-1]) begin
            t_s = -bus.sig_in;
        end else begin
            t_s = bus.sig_in;
        end

        if (t_s >= T_SAT) begin
            p_s = 9'd256;
        end else if (t_s >= T_MID) begin
            p_s = 9'(t_s >> 5) + 9'd216;
        end else if (t_s >= T_ONE) begin
            p_s = 9'(t_s >> 3) + 9'd160;
        end else begin
            p_s = 9'(t_s >> 2) + 9'd128;
        end

        if (bus.sig_in[BITLENGTH-1]) begin
            q_s = 9'd256 - p_s;
        end else begin
            q_s = p_s;
        end

        if (q_s > 9'd255) begin
            prob_s = SIGMOID_BITLENGTH'(8'hFF);
        end else begin
            prob_s = SIGMOID_BITLENGTH'(q_s[7:0]);
        end
    end

    // Seed to load under reset (zero would lock the LFSR) and the free-running step.
    always_comb begin
        if (bus.seed == {SIGMOID_BITLENGTH{1'b0}}) begin
            seed_load_s = SIGMOID_BITLENGTH'(8'h01);
        end else begin
            seed_load_s = bus.seed;
        end
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state register with synchronous seed load.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= seed_load_s;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bus.sum       = sum_s;
    assign bus.prob      = prob_s;
    assign bus.rand_data = lfsr_q;
    assign bus.sample    = (prob_s > lfsr_q);

endmodule

// File: tb/tb_ap_adder_sigmoid_random.sv
// Self-checking bench for ap_adder_sigmoid_random: directed vectors plus
// randomized traffic against a behavioural reference model.
module tb_ap_adder_sigmoid_random;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] m_rand = 8'h00;
    logic [7:0] seq_q[$];

    ap_adder_sigmoid_random_if #(.BITLENGTH(16), .SIGMOID_BITLENGTH(8)) bus ();

    ap_adder_sigmoid_random #(
        .BITLENGTH(16), .SIGMOID_BITLENGTH(8), .INF(16'h7FFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next LFSR state: feedback is the parity of the tapped bits 7,5,4,3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        int ones;
        ones = $countones(s & 8'hB8);
        return {s[6:0], ones[0]};
    endfunction

    function automatic logic [15:0] exp_sum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = $signed(a) + $signed(b);
`ifdef AP_ADDER_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32767) s = -32767;
`endif
        return 16'(s & 32'h0000FFFF);
    endfunction

    function automatic logic [7:0] exp_prob(input logic [15:0] xin);
        int x, t, p, r;
        x = $signed(xin);
        if (x < 0) t = (x == -32768) ? 32767 : -x;
        else       t = x;
        if      (t >= 1280) p = 256;
        else if (t >= 608)  p = t / 32 + 216;
        else if (t >= 256)  p = t / 8 + 160;
        else                p = t / 4 + 128;
        r = (x >= 0) ? p : 256 - p;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    // One rising edge; the model follows the reset/seed values seen at that edge.
    task automatic tick();
        logic       r;
        logic [7:0] sd;
        r  = reset;
        sd = bus.seed;
        @(posedge clock);
        #1;
        if (r) m_rand = (sd == 8'h00) ? 8'h01 : sd;
        else   m_rand = lfsr_step(m_rand);
    endtask

    task automatic drive_check(input logic [15:0] a, input logic [15:0] b, input logic [15:0] x);
        logic [7:0] p;
        bus.add_a  = a;
        bus.add_b  = b;
        bus.sig_in = x;
        #1;
        p = exp_prob(x);
        check_eq("rand_data", 32'(bus.rand_data), 32'(m_rand));
        check_eq("sum", 32'(bus.sum), 32'(exp_sum(a, b)));
        check_eq("prob", 32'(bus.prob), 32'(p));
        check_eq("sample", 32'(bus.sample), 32'(p > m_rand));
    endtask

    logic [15:0] sig_vec[6]  = '{16'h0000, 16'h0100, 16'hFF00, 16'h0500, 16'hFB00, 16'h8000};
    logic [7:0]  prob_vec[6] = '{8'd128, 8'd192, 8'd64, 8'd255, 8'd0, 8'd0};

    initial begin
        logic [7:0] s;
        bus.seed   = 8'h20;
        bus.add_a  = 16'h0000;
        bus.add_b  = 16'h0000;
        bus.sig_in = 16'h0000;

        // Seed 0x20 sequence and sample decisions at prob 128.
        tick();
        check_eq("reset_load", 32'(bus.rand_data), 32'h20);
        reset = 1'b0;
        tick();
        check_eq("seq_41", 32'(bus.rand_data), 32'h41);
        drive_check(16'h0000, 16'h0000, 16'h0000);
        check_eq("sample_41", 32'(bus.sample), 32'd1);
        tick();
        check_eq("seq_82", 32'(bus.rand_data), 32'h82);
        drive_check(16'h0000, 16'h0000, 16'h0000);
        check_eq("sample_82", 32'(bus.sample), 32'd0);
        tick();
        check_eq("seq_05", 32'(bus.rand_data), 32'h05);

        // Directed adder corners.
`ifdef AP_ADDER_SAT_EN
        drive_check(16'h7000, 16'h2000, 16'h0000);
        check_eq("sat_pos", 32'(bus.sum), 32'h7FFF);
        drive_check(16'h8001, 16'hFFFF, 16'h0000);
        check_eq("sat_neg", 32'(bus.sum), 32'h8001);
        drive_check(16'h0100, 16'hFF00, 16'h0000);
        check_eq("sat_zero", 32'(bus.sum), 32'h0000);
`else
        drive_check(16'h7000, 16'h2000, 16'h0000);
        check_eq("wrap", 32'(bus.sum), 32'h9000);
`endif

        // Directed sigmoid points.
        for (int i = 0; i < 6; i++) begin
            drive_check(16'h0000, 16'h0000, sig_vec[i]);
            check_eq("sig_table", 32'(bus.prob), 32'(prob_vec[i]));
        end

        // Zero seed loads 0x01, full period of 255 with no zero state.
        reset    = 1'b1;
        bus.seed = 8'h00;
        tick();
        check_eq("zero_seed", 32'(bus.rand_data), 32'h01);
        reset = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            check_eq("lfsr_model", 32'(bus.rand_data), 32'(m_rand));
            if (bus.rand_data == 8'h00) check_eq("lfsr_nonzero", 32'(bus.rand_data), 32'h01);
            if (i < 254 && bus.rand_data == 8'h01) check_eq("period_early", 32'(i), 32'd254);
        end
        check_eq("period_255", 32'(bus.rand_data), 32'h01);

        // prob equal to rand_data must not sample.
        reset    = 1'b1;
        bus.seed = 8'h80;
        tick();
        drive_check(16'h0000, 16'h0000, 16'h0000);
        check_eq("sample_eq", 32'(bus.sample), 32'd0);

        // Mid-sequence reset replays the same sequence.
        s        = 8'($urandom_range(1, 255));
        bus.seed = s;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seq_q.push_back(bus.rand_data);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_eq("replay", 32'(bus.rand_data), 32'(seq_q[i]));
            tick();
        end

        // Randomized traffic with occasional reseeding.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] x;
            if ($urandom_range(0, 1) == 0) x = 16'($urandom);
            else                            x = 16'($urandom_range(0, 3071)) - 16'd1536;
            drive_check(16'($urandom), 16'($urandom), x);
            if ($urandom_range(0, 39) == 0) begin
                reset    = 1'b1;
                bus.seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end else begin
                reset = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
